// File: rtl/serial_byte_rx.sv
// serial_byte_rx: deserialises a gated LSB-first bit stream into bytes, frames
// them as one header byte plus PKT_BYTES payload bytes, and emits write strobes
// for the payload bytes of packets whose header is HDR_A or HDR_B.
module serial_byte_rx #(
  parameter int unsigned PKT_BYTES = 4,
  parameter logic [7:0]  HDR_A     = 8'hA5,
  parameter logic [7:0]  HDR_B     = 8'hC3
) (
  input  logic       clk_1,
  input  logic       reset,
  input  logic       serial_data,
  input  logic       data_ena,
  input  logic       fifo_full,
  output logic       wr_fifo,
  output logic [7:0] fifo_data,
  output logic       hdr_sel,
  output logic       pkt_done,
  output logic       ovf_err,
  output logic       short_err
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

  logic [2:0] r_bcnt;
  logic [7:0] r_shift;
  logic [1:0] r_state;
  logic [3:0] r_pcnt;

  logic [7:0] w_byte;
  logic       w_done;

  // Incoming bit enters at the MSB; after 8 shifts bit 0 sits at byte[0].
  assign w_byte = {serial_data, r_shift[7:1]};
  assign w_done = data_ena && (r_bcnt == 3'd7);

  // Bit collection and short-byte detection.
  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      r_bcnt    <= '0;
      r_shift   <= '0;
      short_err <= 1'b0;
    end else begin
      short_err <= 1'b0;
      if (data_ena) begin
        r_shift <= w_byte;
        r_bcnt  <= r_bcnt + 3'd1;
      end else if (r_bcnt != 3'd0) begin
        r_bcnt    <= '0;
        r_shift   <= '0;
        short_err <= 1'b1;
      end
    end
  end

  // Packet framing; advances only on the edge that completes a byte.
  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      r_state   <= S_HDR;
      r_pcnt    <= '0;
      wr_fifo   <= 1'b0;
      fifo_data <= '0;
      hdr_sel   <= 1'b0;
      pkt_done  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      wr_fifo  <= 1'b0;
      pkt_done <= 1'b0;
      if (w_done) begin
        case (r_state)
          S_HDR: begin
            r_pcnt <= '0;
            if (w_byte == HDR_A) begin
              hdr_sel <= 1'b0;
              r_state <= S_PAYLOAD;
            end else if (w_byte == HDR_B) begin
              hdr_sel <= 1'b1;
              r_state <= S_PAYLOAD;
            end else begin
              r_state <= S_DISCARD;
            end
          end
          S_PAYLOAD: begin
            if (!fifo_full) begin
              wr_fifo   <= 1'b1;
              fifo_data <= w_byte;
            end else begin
              ovf_err <= 1'b1;
            end
            if (r_pcnt == LAST_IDX) begin
              pkt_done <= 1'b1;
              r_state  <= S_HDR;
            end else begin
              r_pcnt <= r_pcnt + 4'd1;
            end
          end
          S_DISCARD: begin
            if (r_pcnt == LAST_IDX) begin
              r_state <= S_HDR;
            end else begin
              r_pcnt <= r_pcnt + 4'd1;
            end
          end
          default: r_state <= S_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: table-driven byte vectors plus hand-written sequences for
// reset, short bytes and reset in the middle of a packet.
module tb_serial_byte_rx;

  logic       clk_1 = 1'b0;
  logic       reset;
  logic       serial_data;
  logic       data_ena;
  logic       fifo_full;
  logic       wr_fifo;
  logic [7:0] fifo_data;
  logic       hdr_sel;
  logic       pkt_done;
  logic       ovf_err;
  logic       short_err;

  serial_byte_rx #(
    .PKT_BYTES(4),
    .HDR_A    (8'hA5),
    .HDR_B    (8'hC3)
  ) dut (
    .clk_1      (clk_1),
    .reset      (reset),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .fifo_full  (fifo_full),
    .wr_fifo    (wr_fifo),
    .fifo_data  (fifo_data),
    .hdr_sel    (hdr_sel),
    .pkt_done   (pkt_done),
    .ovf_err    (ovf_err),
    .short_err  (short_err)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct {
    logic [7:0] b;
    logic       full;
    logic       gap;
    logic       exp_wr;
    logic [7:0] exp_data;
    logic       exp_done;
    logic       exp_hdr;
    logic       exp_ovf;
  } vec_t;

  vec_t v[$];

  int total = 0;
  int bad   = 0;
  int stray = 0;
  bit pend  = 1'b0;
  int pidx  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic full, input logic gap,
                     input logic wr, input logic [7:0] data, input logic done,
                     input logic hdr, input logic ovf);
    v.push_back('{b, full, gap, wr, data, done, hdr, ovf});
  endtask

  // One clock: sample outputs produced by the previous edge, then drive inputs.
  task automatic do_tick(input logic ena, input logic sd, input logic full);
    @(negedge clk_1);
    if (pend) begin
      chk($sformatf("wr[%0d]", pidx), {7'd0, wr_fifo}, {7'd0, v[pidx].exp_wr});
      if (v[pidx].exp_wr)
        chk($sformatf("data[%0d]", pidx), fifo_data, v[pidx].exp_data);
      chk($sformatf("done[%0d]", pidx), {7'd0, pkt_done}, {7'd0, v[pidx].exp_done});
      chk($sformatf("hdr[%0d]", pidx), {7'd0, hdr_sel}, {7'd0, v[pidx].exp_hdr});
      chk($sformatf("ovf[%0d]", pidx), {7'd0, ovf_err}, {7'd0, v[pidx].exp_ovf});
      chk($sformatf("short[%0d]", pidx), {7'd0, short_err}, 8'd0);
      pend = 1'b0;
    end else if (wr_fifo || pkt_done || short_err) begin
      stray++;
    end
    data_ena    = ena;
    serial_data = sd;
    fifo_full   = full;
  endtask

  task automatic run(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] bb;
        bb = v[k].b;
        do_tick(1'b1, bb[i], v[k].full);
      end
      pend = 1'b1;
      pidx = k;
      if (v[k].gap) do_tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr"},    {7'd0, wr_fifo},   8'd0);
    chk({tag, ".data"},  fifo_data,         8'd0);
    chk({tag, ".hdr"},   {7'd0, hdr_sel},   8'd0);
    chk({tag, ".done"},  {7'd0, pkt_done},  8'd0);
    chk({tag, ".ovf"},   {7'd0, ovf_err},   8'd0);
    chk({tag, ".short"}, {7'd0, short_err}, 8'd0);
  endtask

  initial begin
    // b, full, gap, wr, data, done, hdr, ovf
    // 0-4: A5 packet with idle gaps
    add(8'hA5, 0, 1, 0, 8'h00, 0, 0, 0);
    add(8'h11, 0, 1, 1, 8'h11, 0, 0, 0);
    add(8'h22, 0, 1, 1, 8'h22, 0, 0, 0);
    add(8'h33, 0, 1, 1, 8'h33, 0, 0, 0);
    add(8'h44, 0, 1, 1, 8'h44, 1, 0, 0);
    // 5-9: C3 packet back-to-back
    add(8'hC3, 0, 0, 0, 8'h00, 0, 1, 0);
    add(8'h01, 0, 0, 1, 8'h01, 0, 1, 0);
    add(8'h02, 0, 0, 1, 8'h02, 0, 1, 0);
    add(8'h03, 0, 0, 1, 8'h03, 0, 1, 0);
    add(8'h04, 0, 1, 1, 8'h04, 1, 1, 0);
    // 10-19: bad header packet discarded, then A5 packet
    add(8'h5A, 0, 1, 0, 8'h00, 0, 1, 0);
    add(8'h10, 0, 1, 0, 8'h00, 0, 1, 0);
    add(8'h20, 0, 1, 0, 8'h00, 0, 1, 0);
    add(8'h30, 0, 1, 0, 8'h00, 0, 1, 0);
    add(8'h40, 0, 1, 0, 8'h00, 0, 1, 0);
    add(8'hA5, 0, 1, 0, 8'h00, 0, 0, 0);
    add(8'hAA, 0, 1, 1, 8'hAA, 0, 0, 0);
    add(8'hBB, 0, 1, 1, 8'hBB, 0, 0, 0);
    add(8'hCC, 0, 1, 1, 8'hCC, 0, 0, 0);
    add(8'hDD, 0, 1, 1, 8'hDD, 1, 0, 0);
    // 20-24: FIFO full on 3rd payload byte
    add(8'hA5, 0, 1, 0, 8'h00, 0, 0, 0);
    add(8'h11, 0, 1, 1, 8'h11, 0, 0, 0);
    add(8'h22, 0, 1, 1, 8'h22, 0, 0, 0);
    add(8'h33, 1, 1, 0, 8'h00, 0, 0, 1);
    add(8'h44, 0, 1, 1, 8'h44, 1, 0, 1);
    // 25-29: packet after a short byte
    add(8'hC3, 0, 1, 0, 8'h00, 0, 1, 1);
    add(8'h05, 0, 1, 1, 8'h05, 0, 1, 1);
    add(8'h06, 0, 1, 1, 8'h06, 0, 1, 1);
    add(8'h07, 0, 1, 1, 8'h07, 0, 1, 1);
    add(8'h08, 0, 1, 1, 8'h08, 1, 1, 1);
    // 30: header of a packet interrupted by reset
    add(8'hC3, 0, 0, 0, 8'h00, 0, 1, 1);
    // 31-35: packet after reset
    add(8'hA5, 0, 1, 0, 8'h00, 0, 0, 0);
    add(8'h11, 0, 1, 1, 8'h11, 0, 0, 0);
    add(8'h22, 0, 1, 1, 8'h22, 0, 0, 0);
    add(8'h33, 0, 1, 1, 8'h33, 0, 0, 0);
    add(8'h44, 0, 1, 1, 8'h44, 1, 0, 0);

    reset       = 1'b1;
    data_ena    = 1'b0;
    serial_data = 1'b0;
    fifo_full   = 1'b0;
    @(negedge clk_1);
    @(negedge clk_1);
    chk_all_zero("rst0");
    reset = 1'b0;
    do_tick(1'b0, 1'b0, 1'b0);

    run(0, 4);
    run(5, 9);
    run(10, 19);
    run(20, 24);
    chk("stray_a", 8'(stray), 8'd0);

    // Short byte: 5 bits then data_ena low.
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    @(negedge clk_1);
    chk("short_pulse", {7'd0, short_err}, 8'd1);
    chk("short_nowr",  {7'd0, wr_fifo},   8'd0);
    @(negedge clk_1);
    chk("short_end",   {7'd0, short_err}, 8'd0);
    chk("short_ovf",   {7'd0, ovf_err},   8'd1);
    run(25, 29);

    // Reset in the middle of a payload byte of a C3 packet.
    run(30, 30);
    do_tick(1'b1, 1'b1, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0);
    #2;
    reset    = 1'b1;
    data_ena = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk_1);
    reset = 1'b0;
    do_tick(1'b0, 1'b0, 1'b0);
    run(31, 35);
    do_tick(1'b0, 1'b0, 1'b0);
    chk("stray_b", 8'(stray), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
